// File: rtl/axi4lite_slave_regs_if.sv
// AXI4-Lite bus bundle for the slave register file.
// The slave modport is used by the register file, the master modport by whatever drives it.
interface axi4lite_slave_regs_if #(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32
);
  localparam int unsigned STRBWIDTH = DATAWIDTH / 8;

  logic [ADDRWIDTH-1:0] AWADDR;
  logic                 AWVALID;
  logic                 AWREADY;
  logic [DATAWIDTH-1:0] WDATA;
  logic [STRBWIDTH-1:0] WSTRB;
  logic                 WVALID;
  logic                 WREADY;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;
  logic [ADDRWIDTH-1:0] ARADDR;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [DATAWIDTH-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RVALID;
  logic                 RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave register file with byte strobes, OKAY/SLVERR responses and
// independently accepted write address/data; exposes register contents and write pulses.
module axi4lite_slave_regs #(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUM_REGS  = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  axi4lite_slave_regs_if.slave          bus,
  output logic [NUM_REGS*DATAWIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]           reg_wr_pulse
);
  localparam int unsigned STRBWIDTH = DATAWIDTH / 8;
  localparam int unsigned ADDR_LSB  = $clog2(STRBWIDTH);
  localparam int unsigned IDXW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  function automatic logic addr_ok(input logic [ADDRWIDTH-1:0] a);
    logic [ADDRWIDTH-1:0] idx_full;
    idx_full = a >> ADDR_LSB;
    return (a[ADDR_LSB-1:0] == '0) && (idx_full < ADDRWIDTH'(NUM_REGS));
  endfunction

  function automatic logic [IDXW-1:0] addr_idx(input logic [ADDRWIDTH-1:0] a);
    return IDXW'(a >> ADDR_LSB);
  endfunction

  logic                                aw_held_q, aw_held_d;
  logic                                w_held_q, w_held_d;
  logic [ADDRWIDTH-1:0]                awaddr_q, awaddr_d;
  logic [DATAWIDTH-1:0]                wdata_q, wdata_d;
  logic [STRBWIDTH-1:0]                wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0][DATAWIDTH-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pulse_q, pulse_d;
  logic                                bvalid_q, bvalid_d;
  logic [1:0]                          bresp_q, bresp_d;
  logic                                rvalid_q, rvalid_d;
  logic [1:0]                          rresp_q, rresp_d;
  logic [DATAWIDTH-1:0]                rdata_q, rdata_d;

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0] wr_data;
  logic [STRBWIDTH-1:0] wr_strb;
  logic                 wr_ok, rd_ok;
  logic [IDXW-1:0]      wr_idx, rd_idx;

  // Readys are gated by ARESETN so they read 0 throughout reset.
  assign bus.AWREADY = ARESETN & ~aw_held_q & ~bvalid_q;
  assign bus.WREADY  = ARESETN & ~w_held_q & ~bvalid_q;
  assign bus.ARREADY = ARESETN & ~rvalid_q;

  assign bus.BVALID = bvalid_q;
  assign bus.BRESP  = bresp_q;
  assign bus.RVALID = rvalid_q;
  assign bus.RRESP  = rresp_q;
  assign bus.RDATA  = rdata_q;

  assign reg_q        = regs_q;
  assign reg_wr_pulse = pulse_q;

  assign aw_hs  = bus.AWVALID & bus.AWREADY;
  assign w_hs   = bus.WVALID & bus.WREADY;
  assign ar_hs  = bus.ARVALID & bus.ARREADY;
  assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

  // A held beat takes priority over the live bus, since the live side is not ready then.
  assign wr_addr = aw_held_q ? awaddr_q : bus.AWADDR;
  assign wr_data = w_held_q ? wdata_q : bus.WDATA;
  assign wr_strb = w_held_q ? wstrb_q : bus.WSTRB;

  assign wr_ok  = addr_ok(wr_addr);
  assign wr_idx = addr_idx(wr_addr);
  assign rd_ok  = addr_ok(bus.ARADDR);
  assign rd_idx = addr_idx(bus.ARADDR);

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        awaddr_d  = bus.AWADDR;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = bus.WDATA;
        wstrb_d  = bus.WSTRB;
      end
    end
  end

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit && wr_ok) begin
      for (int b = 0; b < STRBWIDTH; b++) begin
        if (wr_strb[b]) begin
          regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
      if (|wr_strb) begin
        pulse_d[wr_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RespOkay : RespSlverr;
    end else if (bvalid_q && bus.BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_ok ? RespOkay : RespSlverr;
      rdata_d  = rd_ok ? regs_q[rd_idx] : '0;
    end else if (rvalid_q && bus.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      regs_q    <= '0;
      pulse_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: a register model plus response queues
// supply every expected value, checked with immediate assertions.
module tb_axi4lite_slave_regs;
  logic clk;
  logic rst_n;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr_pulse;

  axi4lite_slave_regs_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus ();

  axi4lite_slave_regs #(
    .ADDRWIDTH(32),
    .DATAWIDTH(32),
    .NUM_REGS (16)
  ) dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .bus         (bus),
    .reg_q       (reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic [1:0]  bq[$];
  rd_exp_t     rq[$];
  logic [31:0] mdl[16];
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] flat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = mdl[i];
    return r;
  endfunction

  function automatic bit m_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'd16);
  endfunction

  // W is presented first; AW follows aw_delay cycles later (0 = same cycle).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_delay);
    bit          aw_done = 0;
    bit          w_done  = 0;
    int          cyc     = 0;
    logic [15:0] exp_pulse = '0;
    logic [3:0]  idx;
    logic [1:0]  eb;
    idx = addr[5:2];
    if (m_ok(addr)) begin
      bq.push_back(2'b00);
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
      if (strb != 4'h0) exp_pulse[idx] = 1'b1;
    end else begin
      bq.push_back(2'b10);
    end
    bus.BREADY  = 1'b1;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.WVALID  = 1'b1;
    bus.AWADDR  = addr;
    bus.AWVALID = (aw_delay == 0);
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      if (w_done && !aw_done) chk("wready_low_while_w_held", bus.WREADY, 1'b0);
      if (bus.AWVALID && bus.AWREADY) aw_done = 1;
      if (bus.WVALID && bus.WREADY) w_done = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (aw_done) bus.AWVALID = 1'b0;
      if (w_done) bus.WVALID = 1'b0;
      if (!aw_done && cyc >= aw_delay) bus.AWVALID = 1'b1;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    chk("wr_handshake_done", aw_done && w_done, 1'b1);
    @(negedge clk);
    chk("bvalid_after_commit", bus.BVALID, 1'b1);
    eb = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    chk("bresp", bus.BRESP, eb);
    chk("wr_pulse", reg_wr_pulse, exp_pulse);
    chk("reg_q_after_write", reg_q, flat());
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bvalid_drop", bus.BVALID, 1'b0);
    chk("wr_pulse_one_cycle", reg_wr_pulse, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  // RREADY is held low for 'hold' cycles after RVALID rises.
  task automatic do_read(input logic [31:0] addr, input int hold);
    rd_exp_t e;
    rd_exp_t got;
    bit      done = 0;
    int      cyc  = 0;
    e.data = m_ok(addr) ? mdl[addr[5:2]] : 32'h0;
    e.resp = m_ok(addr) ? 2'b00 : 2'b10;
    rq.push_back(e);
    bus.RREADY  = (hold == 0);
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (bus.ARVALID && bus.ARREADY) done = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.ARVALID = 1'b0;
    chk("ar_handshake_done", done, 1'b1);
    @(negedge clk);
    chk("rvalid_after_ar", bus.RVALID, 1'b1);
    got = (rq.size() > 0) ? rq.pop_front() : 'x;
    chk("rdata", bus.RDATA, got.data);
    chk("rresp", bus.RRESP, got.resp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rvalid_held", bus.RVALID, 1'b1);
      chk("rdata_stable", bus.RDATA, got.data);
      chk("rresp_stable", bus.RRESP, got.resp);
    end
    bus.RREADY = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rvalid_drop", bus.RVALID, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] eb;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", bus.AWREADY, 1'b0);
    chk("rst_wready", bus.WREADY, 1'b0);
    chk("rst_arready", bus.ARREADY, 1'b0);
    chk("rst_bvalid", bus.BVALID, 1'b0);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_bresp", bus.BRESP, 2'b00);
    chk("rst_rresp", bus.RRESP, 2'b00);
    chk("rst_rdata", bus.RDATA, 32'h0);
    chk("rst_reg_q", reg_q, 512'h0);
    chk("rst_pulse", reg_wr_pulse, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", bus.AWREADY, 1'b1);
    chk("post_rst_wready", bus.WREADY, 1'b1);
    chk("post_rst_arready", bus.ARREADY, 1'b1);
    @(posedge clk);
    #1;

    // Full-word write, same-cycle AW/W, then read back
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0);
    do_read(32'h08, 0);

    // W first, AW three cycles later, single-byte strobe
    do_write(32'h08, 32'h0000AA00, 4'b0010, 3);
    do_read(32'h08, 0);

    // Zero strobe: OKAY, no change, no pulse
    do_write(32'h0C, 32'h12345678, 4'h0, 0);

    // Out-of-range and misaligned addresses
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0);
    do_write(32'h09, 32'hCAFEF00D, 4'hF, 0);
    do_read(32'h40, 0);
    do_read(32'h09, 0);

    // Another register, read with RREADY held low
    do_write(32'h3C, 32'hA5A5_5A5A, 4'b1001, 1);
    do_read(32'h3C, 3);

    // BREADY low for 5 cycles with a second write pending
    bus.BREADY = 1'b0;
    bq.push_back(2'b00);
    mdl[3] = 32'h11111111;
    bus.AWADDR = 32'h0C; bus.WDATA = 32'h11111111; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(posedge clk);
    #1;
    bus.AWADDR = 32'h10; bus.WDATA = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_bvalid", bus.BVALID, 1'b1);
      chk("stall_awready", bus.AWREADY, 1'b0);
      chk("stall_wready", bus.WREADY, 1'b0);
      chk("stall_reg_q", reg_q, flat());
      @(posedge clk);
      #1;
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    eb = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    chk("stall_bresp", bus.BRESP, eb);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("resume_bvalid_low", bus.BVALID, 1'b0);
    chk("resume_awready", bus.AWREADY, 1'b1);
    chk("resume_wready", bus.WREADY, 1'b1);
    bq.push_back(2'b00);
    mdl[4] = 32'h22222222;
    @(posedge clk);
    #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge clk);
    chk("second_bvalid", bus.BVALID, 1'b1);
    eb = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    chk("second_bresp", bus.BRESP, eb);
    chk("second_reg_q", reg_q, flat());
    chk("second_pulse", reg_wr_pulse, 16'h0010);
    @(posedge clk);
    #1;

    // Reset while both responses are pending
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    bus.AWADDR = 32'h14; bus.WDATA = 32'h33333333; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h08; bus.ARVALID = 1'b1;
    @(posedge clk);
    #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    @(negedge clk);
    chk("pre_rst_bvalid", bus.BVALID, 1'b1);
    chk("pre_rst_rvalid", bus.RVALID, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_bvalid", bus.BVALID, 1'b0);
    chk("async_rst_rvalid", bus.RVALID, 1'b0);
    chk("async_rst_reg_q", reg_q, 512'h0);
    chk("async_rst_awready", bus.AWREADY, 1'b0);
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    bq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst_b", bus.BVALID, 1'b0);
      chk("no_resp_after_rst_r", bus.RVALID, 1'b0);
    end
    @(posedge clk);
    #1;
    do_read(32'h08, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
